// File: rtl/mem_arbiter.sv
// Two-port byte-wide memory arbiter with lock support.
// Ports: req/we/addr/wdata/lock/ack/rdata per port; RAM side
//   address/o_data/we/i_data; status busy/owner.
module mem_arbiter #(
   parameter int ADDR_W   = 20,
   parameter int LOCK_MAX = 4,
   parameter int PRIO     = 0
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [7:0]        wdata0,
   input  logic [7:0]        wdata1,
   input  logic              lock0,
   input  logic              lock1,
   output logic              ack0,
   output logic              ack1,
   output logic [7:0]        rdata0,
   output logic [7:0]        rdata1,
   output logic [ADDR_W-1:0] address,
   output logic [7:0]        o_data,
   output logic              we,
   input  logic [7:0]        i_data,
   output logic              busy,
   output logic              owner
);

   localparam int CW = $clog2(LOCK_MAX) + 1;
   localparam logic [CW-1:0] CMAX = CW'(LOCK_MAX);

   typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

   state_t        state;
   logic          lock_hold;
   logic [CW-1:0] lock_cnt;

   logic req_own;
   logic req_oth;
   logic locked;
   logic forced;
   logic pick;

   // locked: owner keeps the bus; forced: lock budget spent
   // and the other port is waiting, so it takes over.
   always_comb begin
      req_own = owner ? req1 : req0;
      req_oth = owner ? req0 : req1;
      locked  = lock_hold & req_own;
      forced  = locked & req_oth & (lock_cnt == CMAX);
      pick    = req1;
      if (forced)
         pick = ~owner;
      else if (locked)
         pick = owner;
      else if (req0 & req1)
         pick = (PRIO != 0) ? 1'b0 : ~owner;
   end

   assign busy = (state != IDLE);

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         we        <= 1'b0;
         address   <= '0;
         o_data    <= '0;
         ack0      <= 1'b0;
         ack1      <= 1'b0;
         rdata0    <= '0;
         rdata1    <= '0;
         owner     <= 1'b1;
         lock_hold <= 1'b0;
         lock_cnt  <= '0;
      end else begin
         ack0 <= 1'b0;
         ack1 <= 1'b0;
         unique case (state)
            IDLE: begin
               we <= 1'b0;
               if (!req_own)
                  lock_hold <= 1'b0;
               if (req0 | req1) begin
                  state   <= ADDR;
                  owner   <= pick;
                  address <= pick ? addr1 : addr0;
                  o_data  <= pick ? wdata1 : wdata0;
                  we      <= pick ? we1 : we0;
                  // counter saturates while the other port is idle
                  if (locked && !forced) begin
                     if (lock_cnt != CMAX)
                        lock_cnt <= lock_cnt + 1'b1;
                  end else begin
                     lock_cnt <= '0;
                  end
               end
            end
            ADDR: begin
               we    <= 1'b0;
               state <= DATA;
               if (owner)
                  ack1 <= 1'b1;
               else
                  ack0 <= 1'b1;
               if (!we) begin
                  if (owner)
                     rdata1 <= i_data;
                  else
                     rdata0 <= i_data;
               end
            end
            DATA: begin
               lock_hold <= owner ? lock1 : lock0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter.
// Two instances: round-robin (dut) and fixed priority (pri).
module tb_mem_arbiter;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        req0 = 1'b0, req1 = 1'b0;
   logic        we0 = 1'b0, we1 = 1'b0;
   logic [19:0] addr0 = '0, addr1 = '0;
   logic [7:0]  wdata0 = '0, wdata1 = '0;
   logic        lock0 = 1'b0, lock1 = 1'b0;

   logic        ack0, ack1, we, busy, owner;
   logic [7:0]  rdata0, rdata1, o_data, i_data;
   logic [19:0] address;

   logic        p_ack0, p_ack1, p_we, p_busy, p_owner;
   logic [7:0]  p_rdata0, p_rdata1, p_odata, p_idata;
   logic [19:0] p_address;

   logic [7:0]  ram [4096];
   logic        ld = 1'b0;
   logic [11:0] ld_a = '0;
   logic [7:0]  ld_v = '0;

   int total = 0;
   int bad = 0;

   always #5 clock = ~clock;

   assign i_data  = ram[address[11:0]];
   assign p_idata = ram[p_address[11:0]];

   always @(posedge clock) begin
      if (ld)
         ram[ld_a] <= ld_v;
      else if (we)
         ram[address[11:0]] <= o_data;
   end

   mem_arbiter #(.ADDR_W(20), .LOCK_MAX(4), .PRIO(0)) dut (
      .clock(clock), .reset(reset),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1),
      .wdata0(wdata0), .wdata1(wdata1),
      .lock0(lock0), .lock1(lock1),
      .ack0(ack0), .ack1(ack1),
      .rdata0(rdata0), .rdata1(rdata1),
      .address(address), .o_data(o_data), .we(we),
      .i_data(i_data), .busy(busy), .owner(owner)
   );

   mem_arbiter #(.ADDR_W(20), .LOCK_MAX(4), .PRIO(1)) pri (
      .clock(clock), .reset(reset),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1),
      .wdata0(wdata0), .wdata1(wdata1),
      .lock0(lock0), .lock1(lock1),
      .ack0(p_ack0), .ack1(p_ack1),
      .rdata0(p_rdata0), .rdata1(p_rdata1),
      .address(p_address), .o_data(p_odata), .we(p_we),
      .i_data(p_idata), .busy(p_busy), .owner(p_owner)
   );

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic load(input logic [11:0] a,
                       input logic [7:0] v);
      ld = 1'b1; ld_a = a; ld_v = v;
      tick();
      ld = 1'b0;
   endtask

   task automatic idle_inputs();
      req0 = 1'b0; req1 = 1'b0;
      we0 = 1'b0; we1 = 1'b0;
      lock0 = 1'b0; lock1 = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1'b1;
      tick();
      total++;
      if (ack0 !== 1'b0 || ack1 !== 1'b0) begin
         bad++;
         $display("FAIL rst_ack got %b%b want 00", ack0, ack1);
      end
      total++;
      if (we !== 1'b0) begin
         bad++;
         $display("FAIL rst_we got %b want 0", we);
      end
      total++;
      if (address !== 20'h0 || o_data !== 8'h0) begin
         bad++;
         $display("FAIL rst_addr got %h/%h want 0/0",
                  address, o_data);
      end
      total++;
      if (rdata0 !== 8'h0 || rdata1 !== 8'h0) begin
         bad++;
         $display("FAIL rst_rdata got %h/%h want 0/0",
                  rdata0, rdata1);
      end
      total++;
      if (owner !== 1'b1 || busy !== 1'b0) begin
         bad++;
         $display("FAIL rst_own got %b/%b want 1/0",
                  owner, busy);
      end
      reset = 1'b0;
      // idle forever: nothing moves
      for (int i = 0; i < 6; i++) begin
         tick();
         total++;
         if (busy !== 1'b0 || we !== 1'b0 ||
             ack0 !== 1'b0 || ack1 !== 1'b0) begin
            bad++;
            $display("FAIL idle got busy=%b we=%b ack=%b%b want 0",
                     busy, we, ack0, ack1);
         end
      end
   endtask

   task automatic test_single_read();
      do_reset();
      req0 = 1'b1; we0 = 1'b0; addr0 = 20'h12345;
      tick();
      total++;
      if (address !== 20'h12345 || we !== 1'b0 ||
          busy !== 1'b1 || ack0 !== 1'b0) begin
         bad++;
         $display("FAIL rd_addr got %h we=%b busy=%b ack0=%b want 12345 0 1 0",
                  address, we, busy, ack0);
      end
      tick();
      total++;
      if (ack0 !== 1'b1 || ack1 !== 1'b0) begin
         bad++;
         $display("FAIL rd_ack got %b%b want 10", ack0, ack1);
      end
      total++;
      if (rdata0 !== 8'hA5 || owner !== 1'b0) begin
         bad++;
         $display("FAIL rd_data got %h own=%b want a5 0",
                  rdata0, owner);
      end
      req0 = 1'b0;
      tick();
      total++;
      if (ack0 !== 1'b0 || busy !== 1'b0 || rdata0 !== 8'hA5) begin
         bad++;
         $display("FAIL rd_end got ack=%b busy=%b rd=%h want 0 0 a5",
                  ack0, busy, rdata0);
      end
   endtask

   task automatic test_single_write();
      req1 = 1'b1; we1 = 1'b1;
      addr1 = 20'h00400; wdata1 = 8'h3C;
      tick();
      total++;
      if (we !== 1'b1 || address !== 20'h00400 ||
          o_data !== 8'h3C) begin
         bad++;
         $display("FAIL wr_strobe got we=%b %h %h want 1 00400 3c",
                  we, address, o_data);
      end
      tick();
      total++;
      if (we !== 1'b0 || ack1 !== 1'b1 || ack0 !== 1'b0) begin
         bad++;
         $display("FAIL wr_ack got we=%b ack=%b%b want 0 01",
                  we, ack0, ack1);
      end
      total++;
      if (rdata1 !== 8'h00) begin
         bad++;
         $display("FAIL wr_rdata got %h want 00", rdata1);
      end
      req1 = 1'b0; we1 = 1'b0;
      tick();
      total++;
      if (ram[12'h400] !== 8'h3C || ack1 !== 1'b0) begin
         bad++;
         $display("FAIL wr_mem got %h ack1=%b want 3c 0",
                  ram[12'h400], ack1);
      end
   endtask

   task automatic test_contention();
      logic e0, e1;
      do_reset();
      req0 = 1'b1; req1 = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         tick();
         e0 = (i % 3 == 2) && ((i / 3) % 2 == 0);
         e1 = (i % 3 == 2) && ((i / 3) % 2 == 1);
         total++;
         if (ack0 !== e0 || ack1 !== e1) begin
            bad++;
            $display("FAIL rr cyc%0d got %b%b want %b%b",
                     i, ack0, ack1, e0, e1);
         end
      end
      idle_inputs();
   endtask

   // opening unlocked grant, four locked grants, forced
   // release to port 0, then round-robin back to port 1
   task automatic test_lock();
      logic e0, e1;
      do_reset();
      req1 = 1'b1; lock1 = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (i == 1)
            req0 = 1'b1;
         e0 = (i == 17);
         e1 = (i % 3 == 2) && (i != 17);
         total++;
         if (ack0 !== e0 || ack1 !== e1) begin
            bad++;
            $display("FAIL lock cyc%0d got %b%b want %b%b",
                     i, ack0, ack1, e0, e1);
         end
      end
      idle_inputs();
   endtask

   // lone locked owner: counter must stick at the max so the
   // first contention releases at once
   task automatic test_lock_saturate();
      logic e0, e1;
      do_reset();
      req1 = 1'b1; lock1 = 1'b1;
      for (int i = 1; i <= 23; i++) begin
         tick();
         if (i == 20)
            req0 = 1'b1;
         e0 = (i == 23);
         e1 = (i % 3 == 2) && (i <= 20);
         total++;
         if (ack0 !== e0 || ack1 !== e1) begin
            bad++;
            $display("FAIL lsat cyc%0d got %b%b want %b%b",
                     i, ack0, ack1, e0, e1);
         end
      end
      idle_inputs();
   endtask

   task automatic test_prio();
      logic e0, e1;
      do_reset();
      req0 = 1'b1; req1 = 1'b1;
      for (int i = 1; i <= 11; i++) begin
         tick();
         if (i == 9)
            req0 = 1'b0;
         e0 = (i % 3 == 2) && (i <= 8);
         e1 = (i == 11);
         total++;
         if (p_ack0 !== e0 || p_ack1 !== e1) begin
            bad++;
            $display("FAIL prio cyc%0d got %b%b want %b%b",
                     i, p_ack0, p_ack1, e0, e1);
         end
      end
      idle_inputs();
   endtask

   task automatic test_reset_mid();
      do_reset();
      req1 = 1'b1; we1 = 1'b1;
      addr1 = 20'h00400; wdata1 = 8'h77;
      tick();
      total++;
      if (we !== 1'b1) begin
         bad++;
         $display("FAIL mid_we got %b want 1", we);
      end
      reset = 1'b1;
      req1 = 1'b0; we1 = 1'b0;
      tick();
      reset = 1'b0;
      total++;
      if (we !== 1'b0 || busy !== 1'b0 || ack1 !== 1'b0) begin
         bad++;
         $display("FAIL mid_abort got we=%b busy=%b ack1=%b want 000",
                  we, busy, ack1);
      end
      tick();
      total++;
      if (ack0 !== 1'b0 || ack1 !== 1'b0) begin
         bad++;
         $display("FAIL mid_noack got %b%b want 00", ack0, ack1);
      end
      req0 = 1'b1; addr0 = 20'h12345;
      tick();
      tick();
      total++;
      if (ack0 !== 1'b1 || rdata0 !== 8'hA5) begin
         bad++;
         $display("FAIL mid_next got ack0=%b rd=%h want 1 a5",
                  ack0, rdata0);
      end
      idle_inputs();
      tick();
   endtask

   task automatic test_drop();
      do_reset();
      req0 = 1'b1; addr0 = 20'h12345;
      tick();
      req0 = 1'b0;
      tick();
      total++;
      if (ack0 !== 1'b1) begin
         bad++;
         $display("FAIL drop_ack got %b want 1", ack0);
      end
      tick();
      total++;
      if (ack0 !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL drop_end got ack0=%b busy=%b want 0 0",
                  ack0, busy);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      load(12'h345, 8'hA5);
      load(12'h400, 8'hEE);
      test_reset();
      test_single_read();
      test_single_write();
      test_contention();
      test_lock();
      test_lock_saturate();
      test_prio();
      test_reset_mid();
      test_drop();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
